// File: rtl/issue_stage_param.sv
// issue_stage_param: single-issue stage between the decoder and the ROB/RS/RF.
// It accepts one decoded instruction per cycle, resolves both operands from the
// RF, the ROB read-out, the same-cycle CDB broadcast and the previous issue, and
// emits one registered allocation pulse carrying the new ROB index.
// Optional macro ISSUE_STATS_EN adds saturating issue/stall counters.
module issue_stage_param #(
    parameter int XLEN      = 32,
    parameter int ROB_DEPTH = 64,
    parameter int IDX_W     = 6,
    parameter int REG_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             in_jumped,
    input  logic [5:0]       in_opcode,
    input  logic [REG_W-1:0] in_rs1,
    input  logic [REG_W-1:0] in_rs2,
    input  logic [REG_W-1:0] in_rd,
    input  logic [XLEN-1:0]  in_imm,
    output logic [REG_W-1:0] rf_check1,
    output logic [REG_W-1:0] rf_check2,
    input  logic [XLEN-1:0]  rf_val1,
    input  logic [XLEN-1:0]  rf_val2,
    input  logic [IDX_W-1:0] rf_dep1,
    input  logic [IDX_W-1:0] rf_dep2,
    input  logic             rf_has_dep1,
    input  logic             rf_has_dep2,
    output logic [IDX_W-1:0] rob_check1,
    output logic [IDX_W-1:0] rob_check2,
    input  logic             rob_value_valid1,
    input  logic             rob_value_valid2,
    input  logic [XLEN-1:0]  rob_value1,
    input  logic [XLEN-1:0]  rob_value2,
    input  logic             cdb_valid,
    input  logic [IDX_W-1:0] cdb_idx,
    input  logic [XLEN-1:0]  cdb_value,
    input  logic             rob_full,
    input  logic             rs_full,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_rob_idx,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [5:0]       out_opcode,
    output logic [REG_W-1:0] out_rd,
    output logic             out_jumped,
    output logic [XLEN-1:0]  out_val1,
    output logic [XLEN-1:0]  out_val2,
    output logic [IDX_W-1:0] out_dep1,
    output logic [IDX_W-1:0] out_dep2,
    output logic             out_has_dep1,
    output logic             out_has_dep2
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_stalled
`endif
);

    localparam int RES_W = XLEN + IDX_W + 1;

    logic             fire_p0;
    logic [RES_W-1:0] res1_p0;
    logic [RES_W-1:0] res2_p0;
    logic [IDX_W-1:0] next_idx;
    logic             last_valid;
    logic [REG_W-1:0] last_rd;
    logic [IDX_W-1:0] last_idx;

    // Operand resolution, packed as {has_dep, dep, val}. The previous issue is
    // checked before the RF because its rename is not yet visible in the RF.
    function automatic logic [RES_W-1:0] resolve(
        input logic [REG_W-1:0] rs,
        input logic [XLEN-1:0]  rfv,
        input logic [IDX_W-1:0] rfdep,
        input logic             rfhas,
        input logic             robvv,
        input logic [XLEN-1:0]  robv,
        input logic             lv,
        input logic [REG_W-1:0] lrd,
        input logic [IDX_W-1:0] lidx,
        input logic             cv,
        input logic [IDX_W-1:0] ci,
        input logic [XLEN-1:0]  cval
    );
        logic [RES_W-1:0] r;
        r = '0;
        if (rs == '0) begin
            r = '0;
        end else if (lv && rs == lrd) begin
            if (cv && ci == lidx) r = {1'b0, {IDX_W{1'b0}}, cval};
            else                  r = {1'b1, lidx, {XLEN{1'b0}}};
        end else if (rfhas) begin
            if (robvv)                    r = {1'b0, {IDX_W{1'b0}}, robv};
            else if (cv && ci == rfdep)   r = {1'b0, {IDX_W{1'b0}}, cval};
            else                          r = {1'b1, rfdep, {XLEN{1'b0}}};
        end else begin
            r = {1'b0, {IDX_W{1'b0}}, rfv};
        end
        return r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    assign in_ready   = rdy & ~flush & ~rob_full & ~rs_full;
    assign fire_p0    = in_valid & in_ready;
    assign rf_check1  = in_rs1;
    assign rf_check2  = in_rs2;
    assign rob_check1 = rf_dep1;
    assign rob_check2 = rf_dep2;

    // Resolve both operands combinationally from the current request.
    always_comb begin
        res1_p0 = resolve(in_rs1, rf_val1, rf_dep1, rf_has_dep1, rob_value_valid1, rob_value1,
                          last_valid, last_rd, last_idx, cdb_valid, cdb_idx, cdb_value);
        res2_p0 = resolve(in_rs2, rf_val2, rf_dep2, rf_has_dep2, rob_value_valid2, rob_value2,
                          last_valid, last_rd, last_idx, cdb_valid, cdb_idx, cdb_value);
    end

    // ---- p0 -> p1: allocation register, index counter and bypass record ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_rob_idx  <= '0;
            out_pc       <= '0;
            out_imm      <= '0;
            out_opcode   <= '0;
            out_rd       <= '0;
            out_jumped   <= 1'b0;
            out_val1     <= '0;
            out_val2     <= '0;
            out_dep1     <= '0;
            out_dep2     <= '0;
            out_has_dep1 <= 1'b0;
            out_has_dep2 <= 1'b0;
            next_idx     <= '0;
            last_valid   <= 1'b0;
            last_rd      <= '0;
            last_idx     <= '0;
        end else if (rdy) begin
            if (flush) begin
                out_valid    <= 1'b0;
                out_rob_idx  <= '0;
                out_pc       <= '0;
                out_imm      <= '0;
                out_opcode   <= '0;
                out_rd       <= '0;
                out_jumped   <= 1'b0;
                out_val1     <= '0;
                out_val2     <= '0;
                out_dep1     <= '0;
                out_dep2     <= '0;
                out_has_dep1 <= 1'b0;
                out_has_dep2 <= 1'b0;
                next_idx     <= '0;
                last_valid   <= 1'b0;
                last_rd      <= '0;
                last_idx     <= '0;
            end else if (fire_p0) begin
                out_valid    <= 1'b1;
                out_rob_idx  <= next_idx;
                out_pc       <= in_pc;
                out_imm      <= in_imm;
                out_opcode   <= in_opcode;
                out_rd       <= in_rd;
                out_jumped   <= in_jumped;
                out_val1     <= res1_p0[XLEN-1:0];
                out_val2     <= res2_p0[XLEN-1:0];
                out_dep1     <= res1_p0[XLEN +: IDX_W];
                out_dep2     <= res2_p0[XLEN +: IDX_W];
                out_has_dep1 <= res1_p0[RES_W-1];
                out_has_dep2 <= res2_p0[RES_W-1];
                next_idx     <= (next_idx == IDX_W'(ROB_DEPTH - 1)) ? '0 : next_idx + IDX_W'(1);
                last_valid   <= (in_rd != '0);
                last_rd      <= in_rd;
                last_idx     <= next_idx;
            end else begin
                out_valid    <= 1'b0;
                last_valid   <= 1'b0;
            end
        end
    end

`ifdef ISSUE_STATS_EN
    // Saturating issue and stall counters; only reset clears them, flush does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued  <= '0;
            stat_stalled <= '0;
        end else if (rdy) begin
            if (fire_p0)
                stat_issued <= sat_inc(stat_issued);
            if (in_valid && !in_ready && !flush)
                stat_stalled <= sat_inc(stat_stalled);
        end
    end
`endif

endmodule
